// File: rtl/mux_4to1_case_if.sv
// Bus bundle for mux_4to1_case: data inputs, select/enable, and all mux outputs.
// Optional parity output par_q exists only when MUX_4TO1_CASE_PARITY_EN is defined.
interface mux_4to1_case_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [1:0]       sel;
    logic             en;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic [1:0]       sel_q;
    logic             sel_chg;
`ifdef MUX_4TO1_CASE_PARITY_EN
    logic             par_q;
`endif

    modport master (
        output a, b, c, d, sel, en,
        input  out, out_q, sel_q, sel_chg
`ifdef MUX_4TO1_CASE_PARITY_EN
        , input par_q
`endif
    );

    modport slave (
        input  a, b, c, d, sel, en,
        output out, out_q, sel_q, sel_chg
`ifdef MUX_4TO1_CASE_PARITY_EN
        , output par_q
`endif
    );
endinterface

// File: rtl/mux_4to1_case.sv
// Four-input WIDTH-bit case-decoded selector with combinational and registered outputs.
// Define MUX_4TO1_CASE_PARITY_EN to add the registered even-parity output par_q.
module mux_4to1_case #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux_4to1_case_if.slave     bus
);
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_r_d;
    logic [WIDTH-1:0] out_r_q;
    logic [1:0]       sel_r_d;
    logic [1:0]       sel_r_q;
    logic             chg_d;
    logic             chg_q;

    // Unknown select bits land in default so out is forced to zero rather than X.
    always_comb begin
        out_d = '0;
        case (bus.sel)
            2'd0:    out_d = bus.a;
            2'd1:    out_d = bus.b;
            2'd2:    out_d = bus.c;
            2'd3:    out_d = bus.d;
            default: out_d = '0;
        endcase
    end

    always_comb begin
        out_r_d = out_r_q;
        sel_r_d = sel_r_q;
        chg_d   = 1'b0;
        if (bus.en) begin
            out_r_d = out_d;
            sel_r_d = bus.sel;
            chg_d   = (bus.sel != sel_r_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_r_q <= '0;
            sel_r_q <= 2'd0;
            chg_q   <= 1'b0;
        end else begin
            out_r_q <= out_r_d;
            sel_r_q <= sel_r_d;
            chg_q   <= chg_d;
        end
    end

    assign bus.out     = out_d;
    assign bus.out_q   = out_r_q;
    assign bus.sel_q   = sel_r_q;
    assign bus.sel_chg = chg_q;

`ifdef MUX_4TO1_CASE_PARITY_EN
    logic par_d;
    logic par_q;

    always_comb begin
        par_d = par_q;
        if (bus.en) begin
            par_d = ^out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign bus.par_q = par_q;
`endif
endmodule

// File: tb/tb_mux_4to1_case.sv
// Directed-vector bench for mux_4to1_case; checks combinational select, registered path,
// sel_chg pulses and reset priority, plus par_q when MUX_4TO1_CASE_PARITY_EN is defined.
module tb_mux_4to1_case;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    mux_4to1_case_if #(.WIDTH(4)) bus ();

    mux_4to1_case #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; all drives and samples happen 1 unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b0;
        bus.sel = 2'd0;
        bus.a = 4'h4; bus.b = 4'h1; bus.c = 4'h9; bus.d = 4'h3;
        tick();
        tick();
        n_cmp++; if (bus.out_q !== 4'h0) begin n_err++; $display("FAIL reset_out_q: got %h expected %h", bus.out_q, 4'h0); end
        n_cmp++; if (bus.sel_q !== 2'd0) begin n_err++; $display("FAIL reset_sel_q: got %0d expected %0d", bus.sel_q, 0); end
        n_cmp++; if (bus.sel_chg !== 1'b0) begin n_err++; $display("FAIL reset_sel_chg: got %b expected %b", bus.sel_chg, 1'b0); end
    endtask

    task automatic test_comb_sweep();
        logic [3:0] exp_tab [4];
        exp_tab[0] = 4'h4; exp_tab[1] = 4'h1; exp_tab[2] = 4'h9; exp_tab[3] = 4'h3;
        for (int i = 0; i < 4; i++) begin
            bus.sel = 2'(i);
            #1;
            n_cmp++; if (bus.out !== exp_tab[i]) begin n_err++; $display("FAIL comb_sweep sel=%0d: got %h expected %h", i, bus.out, exp_tab[i]); end
            #4;
        end
    endtask

    task automatic test_input_change();
        rst = 1'b0;
        bus.en = 1'b0;
        tick();
        bus.sel = 2'd2;
        bus.c = 4'h9;
        #1;
        n_cmp++; if (bus.out !== 4'h9) begin n_err++; $display("FAIL in_chg_before: got %h expected %h", bus.out, 4'h9); end
        bus.c = 4'hE;
        #1;
        n_cmp++; if (bus.out !== 4'hE) begin n_err++; $display("FAIL in_chg_after: got %h expected %h", bus.out, 4'hE); end
        n_cmp++; if (bus.out_q !== 4'h0) begin n_err++; $display("FAIL in_chg_out_q_pre: got %h expected %h", bus.out_q, 4'h0); end
        tick();
        n_cmp++; if (bus.out_q !== 4'h0) begin n_err++; $display("FAIL in_chg_out_q_en0: got %h expected %h", bus.out_q, 4'h0); end
        bus.en = 1'b1;
        tick();
        n_cmp++; if (bus.out_q !== 4'hE) begin n_err++; $display("FAIL in_chg_out_q_en1: got %h expected %h", bus.out_q, 4'hE); end
        bus.en = 1'b0;
        bus.c = 4'h9;
    endtask

    task automatic test_reset_release();
        rst = 1'b1;
        bus.sel = 2'd3;
        bus.en = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.out_q !== 4'h0) begin n_err++; $display("FAIL rstrel_hold_out_q: got %h expected %h", bus.out_q, 4'h0); end
        n_cmp++; if (bus.sel_q !== 2'd0) begin n_err++; $display("FAIL rstrel_hold_sel_q: got %0d expected %0d", bus.sel_q, 0); end
        n_cmp++; if (bus.sel_chg !== 1'b0) begin n_err++; $display("FAIL rstrel_hold_chg: got %b expected %b", bus.sel_chg, 1'b0); end
        n_cmp++; if (bus.out !== 4'h3) begin n_err++; $display("FAIL rstrel_comb: got %h expected %h", bus.out, 4'h3); end
        rst = 1'b0;
        tick();
        n_cmp++; if (bus.out_q !== 4'h3) begin n_err++; $display("FAIL rstrel_out_q: got %h expected %h", bus.out_q, 4'h3); end
        n_cmp++; if (bus.sel_q !== 2'd3) begin n_err++; $display("FAIL rstrel_sel_q: got %0d expected %0d", bus.sel_q, 3); end
        n_cmp++; if (bus.sel_chg !== 1'b1) begin n_err++; $display("FAIL rstrel_chg: got %b expected %b", bus.sel_chg, 1'b1); end
        tick();
        n_cmp++; if (bus.sel_chg !== 1'b0) begin n_err++; $display("FAIL rstrel_chg_drop: got %b expected %b", bus.sel_chg, 1'b0); end
        n_cmp++; if (bus.out_q !== 4'h3) begin n_err++; $display("FAIL rstrel_out_q_hold: got %h expected %h", bus.out_q, 4'h3); end
    endtask

    task automatic test_enable_hold();
        bus.en = 1'b0;
        bus.sel = 2'd1;
        #1;
        n_cmp++; if (bus.out !== 4'h1) begin n_err++; $display("FAIL enhold_comb: got %h expected %h", bus.out, 4'h1); end
        tick();
        n_cmp++; if (bus.out_q !== 4'h3) begin n_err++; $display("FAIL enhold_out_q: got %h expected %h", bus.out_q, 4'h3); end
        n_cmp++; if (bus.sel_q !== 2'd3) begin n_err++; $display("FAIL enhold_sel_q: got %0d expected %0d", bus.sel_q, 3); end
        n_cmp++; if (bus.sel_chg !== 1'b0) begin n_err++; $display("FAIL enhold_chg: got %b expected %b", bus.sel_chg, 1'b0); end
        bus.en = 1'b1;
        tick();
        n_cmp++; if (bus.out_q !== 4'h1) begin n_err++; $display("FAIL enhold_cap_out_q: got %h expected %h", bus.out_q, 4'h1); end
        n_cmp++; if (bus.sel_q !== 2'd1) begin n_err++; $display("FAIL enhold_cap_sel_q: got %0d expected %0d", bus.sel_q, 1); end
        n_cmp++; if (bus.sel_chg !== 1'b1) begin n_err++; $display("FAIL enhold_cap_chg: got %b expected %b", bus.sel_chg, 1'b1); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] sels [4];
        logic [3:0] exp_out [4];
        logic       exp_chg [4];
        sels[0] = 2'd0; exp_out[0] = 4'h4; exp_chg[0] = 1'b1;
        sels[1] = 2'd2; exp_out[1] = 4'h9; exp_chg[1] = 1'b1;
        sels[2] = 2'd2; exp_out[2] = 4'h9; exp_chg[2] = 1'b0;
        sels[3] = 2'd3; exp_out[3] = 4'h3; exp_chg[3] = 1'b1;
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.sel = sels[i];
            tick();
            n_cmp++; if (bus.out_q !== exp_out[i]) begin n_err++; $display("FAIL b2b_out_q[%0d]: got %h expected %h", i, bus.out_q, exp_out[i]); end
            n_cmp++; if (bus.sel_q !== sels[i]) begin n_err++; $display("FAIL b2b_sel_q[%0d]: got %0d expected %0d", i, bus.sel_q, sels[i]); end
            n_cmp++; if (bus.sel_chg !== exp_chg[i]) begin n_err++; $display("FAIL b2b_chg[%0d]: got %b expected %b", i, bus.sel_chg, exp_chg[i]); end
        end
    endtask

    task automatic test_data_follow();
        bus.en = 1'b1;
        bus.sel = 2'd3;
        bus.d = 4'hA;
        #1;
        n_cmp++; if (bus.out !== 4'hA) begin n_err++; $display("FAIL follow_comb: got %h expected %h", bus.out, 4'hA); end
        n_cmp++; if (bus.out_q !== 4'h3) begin n_err++; $display("FAIL follow_out_q_pre: got %h expected %h", bus.out_q, 4'h3); end
        tick();
        n_cmp++; if (bus.out_q !== 4'hA) begin n_err++; $display("FAIL follow_out_q: got %h expected %h", bus.out_q, 4'hA); end
        n_cmp++; if (bus.sel_chg !== 1'b0) begin n_err++; $display("FAIL follow_chg: got %b expected %b", bus.sel_chg, 1'b0); end
        bus.d = 4'h3;
    endtask

    task automatic test_mid_reset();
        bus.en = 1'b1;
        bus.sel = 2'd1;
        rst = 1'b1;
        tick();
        n_cmp++; if (bus.out_q !== 4'h0) begin n_err++; $display("FAIL midrst_out_q: got %h expected %h", bus.out_q, 4'h0); end
        n_cmp++; if (bus.sel_q !== 2'd0) begin n_err++; $display("FAIL midrst_sel_q: got %0d expected %0d", bus.sel_q, 0); end
        n_cmp++; if (bus.sel_chg !== 1'b0) begin n_err++; $display("FAIL midrst_chg: got %b expected %b", bus.sel_chg, 1'b0); end
        bus.b = 4'h7;
        #1;
        n_cmp++; if (bus.out !== 4'h7) begin n_err++; $display("FAIL midrst_comb: got %h expected %h", bus.out, 4'h7); end
        bus.b = 4'h1;
        rst = 1'b0;
        tick();
        n_cmp++; if (bus.out_q !== 4'h1) begin n_err++; $display("FAIL midrst_rel_out_q: got %h expected %h", bus.out_q, 4'h1); end
        n_cmp++; if (bus.sel_chg !== 1'b1) begin n_err++; $display("FAIL midrst_rel_chg: got %b expected %b", bus.sel_chg, 1'b1); end
    endtask

    task automatic test_x_sel();
        logic [1:0] sel_drv;
        logic [3:0] exp_tab [4];
        logic [3:0] exp_v;
        exp_tab[0] = 4'h4; exp_tab[1] = 4'h1; exp_tab[2] = 4'h9; exp_tab[3] = 4'h3;
        sel_drv = 2'bxx;
        // A two-state simulator resolves the X to a legal code, so expect that input instead.
        if ($isunknown(sel_drv)) exp_v = 4'h0;
        else exp_v = exp_tab[sel_drv];
        bus.sel = sel_drv;
        #1;
        n_cmp++; if (bus.out !== exp_v) begin n_err++; $display("FAIL x_sel: got %h expected %h", bus.out, exp_v); end
        bus.sel = 2'd0;
    endtask

`ifdef MUX_4TO1_CASE_PARITY_EN
    task automatic test_parity();
        bus.en = 1'b1;
        bus.sel = 2'd2;
        tick();
        n_cmp++; if (bus.par_q !== 1'b0) begin n_err++; $display("FAIL parity_c9: got %b expected %b", bus.par_q, 1'b0); end
        bus.sel = 2'd1;
        tick();
        n_cmp++; if (bus.par_q !== 1'b1) begin n_err++; $display("FAIL parity_b1: got %b expected %b", bus.par_q, 1'b1); end
        bus.en = 1'b0;
        bus.sel = 2'd2;
        tick();
        n_cmp++; if (bus.par_q !== 1'b1) begin n_err++; $display("FAIL parity_hold: got %b expected %b", bus.par_q, 1'b1); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.par_q !== 1'b0) begin n_err++; $display("FAIL parity_rst: got %b expected %b", bus.par_q, 1'b0); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.sel = 2'd0;
        bus.a = 4'h4; bus.b = 4'h1; bus.c = 4'h9; bus.d = 4'h3;
        #1;
        test_reset();
        test_comb_sweep();
        test_input_change();
        test_reset_release();
        test_enable_hold();
        test_back_to_back();
        test_data_follow();
        test_mid_reset();
        test_x_sel();
`ifdef MUX_4TO1_CASE_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mux_4to1_case.md
Name: mux_4to1_case

Overview:
- Four-input, WIDTH-bit data selector, with the select decoded by a full case statement.
- Provides a purely combinational output `out` that follows `sel` and the data inputs with no clock dependency.
- Also provides a registered copy `out_q` plus select-tracking status for downstream synchronous logic.
- Used as a generic leaf datapath selector.

Parameters:
- WIDTH, 4, bit width of each data input and of both data outputs.

Ports:
- clk  input  1  rising-edge clock for all registered outputs.
- rst  input  1  synchronous active-high reset.
- a  input  WIDTH  data input 0, selected when sel=2'd0.
- b  input  WIDTH  data input 1, selected when sel=2'd1.
- c  input  WIDTH  data input 2, selected when sel=2'd2.
- d  input  WIDTH  data input 3, selected when sel=2'd3.
- sel  input  2  select code.
- en  input  1  capture enable for the registered path.
- out  output  WIDTH  combinational mux result.
- out_q  output  WIDTH  registered mux result.
- sel_q  output  2  registered select.
- sel_chg  output  1  one-cycle pulse, high when a captured sel differs from the previous sel_q.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. It is sampled only on the rising edge of clk and has no effect on `out`.
- Combinational path:
  - sel 0→a, 1→b, 2→c, 3→d, implemented as a case statement.
  - Any non-0/1 bit on sel drives `out` to all zeros (default branch); no X propagation by design.
  - `out` updates in the same simulation timestep as any change on a/b/c/d/sel; zero latency, no clock required.
- Registered path, evaluated on each rising clk edge:
  - If rst=1: out_q←0, sel_q←2'd0, sel_chg←0. rst has priority over en.
  - Else if en=1: out_q←current `out`, sel_q←sel, sel_chg←(sel≠sel_q).
  - Else (en=0): out_q and sel_q hold; sel_chg←0.
- Latency: out_q and sel_q lag the inputs by exactly one clock.
- sel_chg:
  - Asserts for exactly one cycle after each enabled capture that changes the select.
  - Repeated captures of the same sel keep sel_chg low.
  - The first enabled capture after reset with sel≠0 asserts sel_chg.
- Reset mid-operation: registered outputs return to 0 on the next edge; `out` keeps tracking inputs throughout.
- Data inputs changing while sel is stable: `out` follows immediately; out_q follows on the next enabled edge.
- Widths: no arithmetic. All data paths are exactly WIDTH bits, with no truncation or extension.

Optional Feature:
- Macro: MUX_4TO1_CASE_PARITY_EN.
- When defined:
  - Adds output port `par_q` (1 bit): the registered even parity (XOR-reduce) of `out`.
  - Updated with the same rst/en rules as out_q; reset value 0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Combinational select sweep, no clock: a=4'h4, b=4'h1, c=4'h9, d=4'h3; step sel 0,1,2,3 every 5 time units → out = 4, 1, 9, 3 respectively, with no delay.
- Input change at fixed sel: sel=2, change c from 4'h9 to 4'hE → out=4'hE in the same timestep; out_q unchanged until the next enabled edge.
- Reset behaviour: hold rst=1 for 2 edges with sel=3, en=1 → out_q=0, sel_q=0, sel_chg=0. Release rst → next edge out_q=4'h3, sel_q=3, sel_chg=1; following edge sel_chg=0.
- Enable hold: en=0 while sel moves 3→1 → out=4'h1 immediately, while out_q stays 4'h3, sel_q stays 3, sel_chg stays 0. Set en=1 → out_q=4'h1, sel_chg=1.
- X on sel: drive sel=2'bx → out=4'h0.
- With MUX_4TO1_CASE_PARITY_EN defined: sel=2 (c=4'h9), en=1 → par_q=0 after the edge. With sel=1 (b=4'h1) → par_q=1.
